// File: rtl/rr_arb8.sv
// Eight-requester round-robin arbiter with a registered grant index and valid.
// Rotating priority pointer plus a hold timeout bound each grant's tenure.
module rr_arb8 #(
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   output logic [2:0] grant_idx,
   output logic       grant_valid
);

   localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] ptr_q, ptr_d;
   logic [3:0] hold_cnt_q, hold_cnt_d;
   logic [2:0] grant_idx_q, grant_idx_d;
   logic       grant_valid_q, grant_valid_d;

   logic [2:0] pick_idx;
   logic       pick_found;

   // Circular priority search starting at ptr_q; first hit wins.
   always_comb begin
      pick_idx   = ptr_q;
      pick_found = 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (!pick_found && req[ptr_q + 3'(i)]) begin
            pick_idx   = ptr_q + 3'(i);
            pick_found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      hold_cnt_d    = hold_cnt_q;
      grant_idx_d   = grant_idx_q;
      grant_valid_d = grant_valid_q;
      case (state_q)
         IDLE: begin
            grant_valid_d = 1'b0;
            if (pick_found) begin
               grant_idx_d   = pick_idx;
               grant_valid_d = 1'b1;
               hold_cnt_d    = 4'd1;
               state_d       = GRANT;
            end
         end
         GRANT: begin
            if (!req[grant_idx_q] || (hold_cnt_q == MAX_HOLD_C)) begin
               grant_valid_d = 1'b0;
               ptr_d         = grant_idx_q + 3'd1;
               hold_cnt_d    = '0;
               state_d       = IDLE;
            end else begin
               hold_cnt_d = hold_cnt_q + 4'd1;
            end
         end
         default: begin
            grant_valid_d = 1'b0;
            hold_cnt_d    = '0;
            state_d       = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         hold_cnt_q    <= '0;
         grant_idx_q   <= '0;
         grant_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         hold_cnt_q    <= hold_cnt_d;
         grant_idx_q   <= grant_idx_d;
         grant_valid_q <= grant_valid_d;
      end
   end

   assign grant_idx   = grant_idx_q;
   assign grant_valid = grant_valid_q;

endmodule

// File: tb/tb_rr_arb8.sv
// Directed self-checking bench for rr_arb8 (MAX_HOLD = 4 and MAX_HOLD = 1 instances).
module tb_rr_arb8;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic [2:0] gi, gi1;
   logic       gv, gv1;

   int n_cmp = 0;
   int n_err = 0;

   rr_arb8 #(.MAX_HOLD(4)) dut (
      .clk(clk), .rst(rst), .req(req), .grant_idx(gi), .grant_valid(gv)
   );

   rr_arb8 #(.MAX_HOLD(1)) dut1 (
      .clk(clk), .rst(rst), .req(req), .grant_idx(gi1), .grant_valid(gv1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req = '0;
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      req = 8'hFF;
      rst = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (gv !== 1'b0 || gi !== 3'd0) begin
            n_err++;
            $display("FAIL reset_hold[%0d]: got valid=%b idx=%0d, want valid=0 idx=0", i, gv, gi);
         end
         step();
      end
      n_cmp++;
      if (gv !== 1'b0 || gi !== 3'd0) begin
         n_err++;
         $display("FAIL reset_hold_end: got valid=%b idx=%0d, want valid=0 idx=0", gv, gi);
      end
      rst = 1'b0;
      step();
      n_cmp++;
      if (gv !== 1'b1 || gi !== 3'd0) begin
         n_err++;
         $display("FAIL reset_first_grant: got valid=%b idx=%0d, want valid=1 idx=0", gv, gi);
      end
      req = '0;
      step();
      n_cmp++;
      if (gv !== 1'b0 || gi !== 3'd0) begin
         n_err++;
         $display("FAIL reset_release: got valid=%b idx=%0d, want valid=0 idx=0", gv, gi);
      end
   endtask

   task automatic test_rotation();
      logic [2:0] seq [4] = '{3'd0, 3'd2, 3'd7, 3'd0};
      do_reset();
      req = 8'b1000_0101;
      for (int g = 0; g < 4; g++) begin
         for (int c = 0; c < 5; c++) begin
            step();
            n_cmp++;
            if (gv !== (c < 4) || gi !== seq[g]) begin
               n_err++;
               $display("FAIL rotation g%0d c%0d: got valid=%b idx=%0d, want valid=%0d idx=%0d",
                        g, c, gv, gi, (c < 4), seq[g]);
            end
         end
      end
      req = '0;
      step();
   endtask

   task automatic test_early_release();
      req = 8'b0000_1000;
      for (int c = 0; c < 2; c++) begin
         step();
         n_cmp++;
         if (gv !== 1'b1 || gi !== 3'd3) begin
            n_err++;
            $display("FAIL early_hold c%0d: got valid=%b idx=%0d, want valid=1 idx=3", c, gv, gi);
         end
      end
      req = '0;
      step();
      n_cmp++;
      if (gv !== 1'b0 || gi !== 3'd3) begin
         n_err++;
         $display("FAIL early_release: got valid=%b idx=%0d, want valid=0 idx=3", gv, gi);
      end
      req = 8'b0000_1001;
      step();
      n_cmp++;
      if (gv !== 1'b1 || gi !== 3'd0) begin
         n_err++;
         $display("FAIL early_next_pick: got valid=%b idx=%0d, want valid=1 idx=0", gv, gi);
      end
      req = '0;
      step();
      step();
   endtask

   task automatic test_timeout();
      req = 8'b0010_0000;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 5; c++) begin
            step();
            n_cmp++;
            if (gv !== (c < 4) || gi !== 3'd5) begin
               n_err++;
               $display("FAIL timeout r%0d c%0d: got valid=%b idx=%0d, want valid=%0d idx=5",
                        r, c, gv, gi, (c < 4));
            end
         end
      end
      req = '0;
      step();
   endtask

   task automatic test_async_reset();
      do_reset();
      req = 8'b0100_0000;
      step();
      step();
      n_cmp++;
      if (gv !== 1'b1 || gi !== 3'd6) begin
         n_err++;
         $display("FAIL async_pre: got valid=%b idx=%0d, want valid=1 idx=6", gv, gi);
      end
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (gv !== 1'b0 || gi !== 3'd0) begin
         n_err++;
         $display("FAIL async_drop: got valid=%b idx=%0d, want valid=0 idx=0", gv, gi);
      end
      step();
      rst = 1'b0;
      req = 8'b0100_0010;
      step();
      n_cmp++;
      if (gv !== 1'b1 || gi !== 3'd1) begin
         n_err++;
         $display("FAIL async_first_pick: got valid=%b idx=%0d, want valid=1 idx=1", gv, gi);
      end
      req = '0;
      step();
   endtask

   task automatic test_no_preempt();
      logic       exp_v [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [2:0] exp_i [10] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
      do_reset();
      req = 8'b0000_0100;
      for (int c = 0; c < 10; c++) begin
         if (c == 1) req = 8'b0000_0111;
         if (c == 3) req = 8'b0000_0011;
         step();
         n_cmp++;
         if (gv !== exp_v[c] || gi !== exp_i[c]) begin
            n_err++;
            $display("FAIL no_preempt c%0d: got valid=%b idx=%0d, want valid=%b idx=%0d",
                     c, gv, gi, exp_v[c], exp_i[c]);
         end
      end
      req = '0;
      step();
   endtask

   task automatic test_max_hold1();
      logic       exp_v [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [2:0] exp_i [5] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd0};
      do_reset();
      req = 8'b0000_0011;
      for (int c = 0; c < 5; c++) begin
         step();
         n_cmp++;
         if (gv1 !== exp_v[c] || gi1 !== exp_i[c]) begin
            n_err++;
            $display("FAIL max_hold1 c%0d: got valid=%b idx=%0d, want valid=%b idx=%0d",
                     c, gv1, gi1, exp_v[c], exp_i[c]);
         end
      end
      req = '0;
      step();
   endtask

   initial begin
      rst = 1'b1;
      req = '0;
      test_reset();
      test_rotation();
      test_early_release();
      test_timeout();
      test_async_reset();
      test_no_preempt();
      test_max_hold1();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
